val2_shift_unit: RTL and testbench
==================================

Name: val2_shift_unit

Overview:
- Multi-cycle, parametrised successor to the combinational Val2 generator in the EXE stage.
- Computes the ARM data-processing / memory second operand (val2) and the shifter carry-out.
- Shifts iteratively, STEP bits per cycle, behind a valid/ready handshake on both sides. The EXE stage stalls on in_ready/out_valid.
- Adds behaviour the combinational block lacks: full ARM shifter semantics (LSR/ASR #0 means 32, ROR #0 means RRX), correct ASR sign fill, correct ROR, carry-out, and backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be >=32.
- STEP, 4, bits shifted per SHIFT cycle; power of two, 1..32.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept; high iff state==IDLE.
- val_rm  input  WIDTH  Rm register value.
- imm  input  1  I bit: immediate operand.
- shift_operand  input  12  instruction bits [11:0].
- is_memory_ins  input  1  LDR/STR: 12-bit offset.
- carry_in  input  1  CPSR C flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- val2  output  WIDTH  result operand.
- carry_out  output  1  shifter carry-out.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State goes to IDLE; val2=0, carry_out=0, out_valid=0, busy=0, in_ready=1.
  - Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately; nothing is emitted.
- FSM states: IDLE, SHIFT, DONE.
- Accept: in_valid && in_ready at a rising edge.
  - All inputs are captured into an internal data register, a remaining-count register (6 bits), a mode register and a carry register.
  - Inputs are ignored at all other times.
- Decode at accept (priority order):
  1. is_memory_ins: data = zero-extended shift_operand, carry = carry_in, count = 0.
  2. imm: data = zero-extended shift_operand[7:0]; mode = ROR; count = 2*shift_operand[11:8]; carry = carry_in.
  3. Register operand: type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amt = shift_operand[11:7]; data = val_rm; carry = carry_in.
     - LSL amt: count = amt.
     - LSR/ASR amt 0: count = 32.
     - ROR amt 0: mode = RRX, count = 1.
     - Otherwise count = amt.
- Transitions:
  - count == 0 → DONE; otherwise → SHIFT.
- SHIFT, each cycle:
  - n = min(STEP, remaining).
  - Shift data by n:
    - LSL: zero fill.
    - LSR: zero fill.
    - ASR: sign fill from bit WIDTH-1.
    - ROR: rotate over WIDTH bits.
    - RRX: result = {carry, data[WIDTH-1:1]}.
  - carry = last bit shifted out (for LSL: bit WIDTH-n; otherwise bit n-1).
  - remaining -= n; when remaining reaches 0 → DONE.
- Latency: k = ceil(count/STEP).
  - count 0: out_valid rises 1 cycle after the accept edge.
  - count > 0: out_valid rises k+1 cycles after the accept edge.
- DONE:
  - out_valid = 1; val2 and carry_out hold the registered result.
  - Both stay stable while out_ready = 0, for an unbounded number of cycles.
  - out_valid && out_ready → IDLE next cycle.
  - No new accept is possible in the same cycle.
- Immediate carry-out: if count != 0, carry_out = final val2[31]. This matches the last bit rotated out for WIDTH=32.
- val2 and carry_out hold their last value in IDLE/SHIFT. Consumers sample only on out_valid.
- Count 32 with WIDTH=32:
  - LSR: result 0, carry = bit31.
  - ASR: result all sign bits, carry = bit31.
- Count is bounded at 32 (5-bit amt, 2*15=30, or 32); no wrap.

Test Plan:
- LSL: imm=0, mem=0, val_rm=0x000000F1, shift_operand=0x200 (LSL #4), STEP=4 → val2=0x00000F10, carry_out=0, out_valid 2 cycles after accept.
- ASR #0: val_rm=0x80000000, shift_operand=0x040 → val2=0xFFFFFFFF, carry_out=1, out_valid 9 cycles after accept.
- RRX: val_rm=0x00000003, shift_operand=0x060, carry_in=1 → val2=0x80000001, carry_out=1, out_valid 2 cycles after accept.
- Immediate: imm=1, shift_operand=0x4FF → val2=0xFF000000, carry_out=1, out_valid 3 cycles after accept.
- Memory priority: is_memory_ins=1, imm=1, shift_operand=0xABC, carry_in=0 → val2=0x00000ABC, carry_out=0, out_valid 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → val2/out_valid stable, in_ready=0.
  - Then start a new ASR #0 and drop rst_n during SHIFT → out_valid=0, in_ready=1, val2=0 immediately.
  - After rst_n rises, a fresh LSL request completes normally.

Source files
------------

// File: rtl/val2_shift_unit.sv
// Iterative ARM second-operand (val2) shifter for the EXE stage.
// Shifts STEP bits per cycle behind valid/ready handshakes and produces the shifter carry-out.
module val2_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_rm,
    input  logic             imm,
    input  logic [11:0]      shift_operand,
    input  logic             is_memory_ins,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val2,
    output logic             carry_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_LSR = 3'd1,
        MODE_ASR = 3'd2,
        MODE_ROR = 3'd3,
        MODE_RRX = 3'd4
    } mode_t;

    localparam logic [31:0] WIDTH_L = WIDTH;
    localparam logic [5:0]  STEP_L  = 6'(STEP);

    state_t            r_state;
    mode_t             r_mode;
    logic [WIDTH-1:0]  r_data;
    logic [5:0]        r_remaining;
    logic              r_carry;
    logic              r_immRot;

    logic [WIDTH-1:0]  w_decData;
    logic [5:0]        w_decCount;
    mode_t             w_decMode;
    logic              w_decImmRot;

    logic [5:0]        w_n;
    logic [31:0]       w_nExt;
    logic [WIDTH-1:0]  w_lslOut;
    logic [WIDTH-1:0]  w_lowOut;
    logic [WIDTH-1:0]  w_shData;
    logic              w_shCarry;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);

    // Operand decode: memory offset beats immediate, which beats register-shift form.
    always_comb begin
        w_decData   = val_rm;
        w_decCount  = 6'd0;
        w_decMode   = MODE_LSL;
        w_decImmRot = 1'b0;
        if (is_memory_ins) begin
            w_decData = {{(WIDTH-12){1'b0}}, shift_operand};
        end else if (imm) begin
            w_decData   = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
            w_decMode   = MODE_ROR;
            w_decCount  = {1'b0, shift_operand[11:8], 1'b0};
            w_decImmRot = (shift_operand[11:8] != 4'd0);
        end else begin
            case (shift_operand[6:5])
                2'b00: begin
                    w_decMode  = MODE_LSL;
                    w_decCount = {1'b0, shift_operand[11:7]};
                end
                2'b01: begin
                    w_decMode  = MODE_LSR;
                    w_decCount = (shift_operand[11:7] == 5'd0) ? 6'd32 : {1'b0, shift_operand[11:7]};
                end
                2'b10: begin
                    w_decMode  = MODE_ASR;
                    w_decCount = (shift_operand[11:7] == 5'd0) ? 6'd32 : {1'b0, shift_operand[11:7]};
                end
                default: begin
                    if (shift_operand[11:7] == 5'd0) begin
                        w_decMode  = MODE_RRX;
                        w_decCount = 6'd1;
                    end else begin
                        w_decMode  = MODE_ROR;
                        w_decCount = {1'b0, shift_operand[11:7]};
                    end
                end
            endcase
        end
    end

    assign w_n    = (r_remaining > STEP_L) ? STEP_L : r_remaining;
    assign w_nExt = {26'd0, w_n};

    // One shift step of n bits; carry is the last bit to leave the register.
    always_comb begin
        w_lslOut  = r_data >> (WIDTH_L - w_nExt);
        w_lowOut  = r_data >> (w_nExt - 32'd1);
        w_shData  = r_data;
        w_shCarry = r_carry;
        case (r_mode)
            MODE_LSL: begin
                w_shData  = r_data << w_nExt;
                w_shCarry = w_lslOut[0];
            end
            MODE_LSR: begin
                w_shData  = r_data >> w_nExt;
                w_shCarry = w_lowOut[0];
            end
            MODE_ASR: begin
                w_shData  = $signed(r_data) >>> w_nExt;
                w_shCarry = w_lowOut[0];
            end
            MODE_ROR: begin
                w_shData  = (r_data >> w_nExt) | (r_data << (WIDTH_L - w_nExt));
                w_shCarry = w_lowOut[0];
            end
            MODE_RRX: begin
                w_shData  = {r_carry, r_data[WIDTH-1:1]};
                w_shCarry = r_data[0];
            end
            default: begin
                w_shData  = r_data;
                w_shCarry = r_carry;
            end
        endcase
    end

    // Result registers load on the first DONE cycle and then hold until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= MODE_LSL;
            r_data      <= '0;
            r_remaining <= 6'd0;
            r_carry     <= 1'b0;
            r_immRot    <= 1'b0;
            val2        <= '0;
            carry_out   <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data      <= w_decData;
                        r_remaining <= w_decCount;
                        r_mode      <= w_decMode;
                        r_carry     <= carry_in;
                        r_immRot    <= w_decImmRot;
                        r_state     <= (w_decCount == 6'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_data      <= w_shData;
                    r_carry     <= w_shCarry;
                    r_remaining <= r_remaining - w_n;
                    if (r_remaining == w_n) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        val2      <= r_data;
                        carry_out <= r_immRot ? r_data[31] : r_carry;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_val2_shift_unit.sv
// Self-checking bench for val2_shift_unit: directed cases, backpressure, mid-shift reset,
// and randomized requests compared with a one-shot arithmetic model of the ARM shifter.
module tb_val2_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic        is_memory_ins;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val2;
    logic        carry_out;
    logic        busy;

    int compareCount = 0;
    int failCount    = 0;

    val2_shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .val_rm       (val_rm),
        .imm          (imm),
        .shift_operand(shift_operand),
        .is_memory_ins(is_memory_ins),
        .carry_in     (carry_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .val2         (val2),
        .carry_out    (carry_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int a);
        if (a == 0) return x;
        return (x >> a) | (x << (32 - a));
    endfunction

    // Whole shift done at once on a 64-bit window; latency from ceil(count/4).
    function automatic void refModel(input logic [31:0] rm, input logic im, input logic [11:0] so,
                                     input logic mem, input logic cin,
                                     output logic [31:0] v, output logic c, output int lat);
        int          cnt;
        int          a;
        logic [63:0] wide;
        cnt = 0;
        v   = rm;
        c   = cin;
        if (mem) begin
            v = {20'd0, so};
        end else if (im) begin
            a   = 2 * int'(so[11:8]);
            cnt = a;
            v   = rotr({24'd0, so[7:0]}, a);
            if (a != 0) c = v[31];
        end else begin
            a = int'(so[11:7]);
            case (so[6:5])
                2'b00: begin
                    cnt = a;
                    if (a != 0) begin
                        wide = {32'd0, rm} << a;
                        v    = wide[31:0];
                        c    = wide[32];
                    end
                end
                2'b01: begin
                    if (a == 0) a = 32;
                    cnt  = a;
                    wide = {rm, 32'd0} >> a;
                    v    = wide[63:32];
                    c    = wide[31];
                end
                2'b10: begin
                    if (a == 0) a = 32;
                    cnt  = a;
                    wide = $signed({rm, 32'd0}) >>> a;
                    v    = wide[63:32];
                    c    = wide[31];
                end
                default: begin
                    if (a == 0) begin
                        cnt = 1;
                        v   = {cin, rm[31:1]};
                        c   = rm[0];
                    end else begin
                        cnt = a;
                        v   = rotr(rm, a);
                        c   = v[31];
                    end
                end
            endcase
        end
        lat = (cnt == 0) ? 1 : (cnt + 3) / 4 + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] rm, input logic im, input logic [11:0] so,
                                 input logic mem, input logic cin, output int lat);
        @(negedge clk);
        val_rm        = rm;
        imm           = im;
        shift_operand = so;
        is_memory_ins = mem;
        carry_in      = cin;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        val_rm        = $urandom;
        shift_operand = 12'($urandom);
        imm           = 1'($urandom);
        is_memory_ins = 1'($urandom);
        carry_in      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] rm, input logic im,
                           input logic [11:0] so, input logic mem, input logic cin,
                           input int holdCycles);
        logic [31:0] expV;
        logic        expC;
        int          expLat;
        int          lat;
        refModel(rm, im, so, mem, cin, expV, expC, expLat);
        applyStimulus(rm, im, so, mem, cin, lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " val2"}, 64'(val2), 64'(expV));
        checkOutput({tag, " carry_out"}, 64'(carry_out), 64'(expC));
        for (int i = 0; i < holdCycles; i++) begin
            in_valid      = 1'b1;
            val_rm        = $urandom;
            shift_operand = 12'($urandom);
            @(posedge clk);
            #1;
            checkOutput({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, " hold val2"}, 64'(val2), 64'(expV));
            checkOutput({tag, " hold carry_out"}, 64'(carry_out), 64'(expC));
            checkOutput({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " release out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " release in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] rRm;
        logic [11:0] rSo;
        logic        rImm;
        logic        rMem;
        int          lat;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        val_rm        = '0;
        imm           = 1'b0;
        shift_operand = '0;
        is_memory_ins = 1'b0;
        carry_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset val2", 64'(val2), 64'd0);
        checkOutput("reset carry_out", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runCase("lsl4", 32'h0000_00F1, 1'b0, 12'h200, 1'b0, 1'b0, 0);
        runCase("asr0", 32'h8000_0000, 1'b0, 12'h040, 1'b0, 1'b0, 0);
        runCase("rrx", 32'h0000_0003, 1'b0, 12'h060, 1'b0, 1'b1, 0);
        runCase("imm", 32'h1234_5678, 1'b1, 12'h4FF, 1'b0, 1'b0, 0);
        runCase("mem", 32'h1234_5678, 1'b1, 12'hABC, 1'b1, 1'b0, 0);
        runCase("lsr0", 32'h8000_0001, 1'b0, 12'h020, 1'b0, 1'b0, 0);
        runCase("ror31", 32'hF000_000F, 1'b0, 12'hFE0, 1'b0, 1'b0, 0);
        runCase("lsl0", 32'hDEAD_BEEF, 1'b0, 12'h000, 1'b0, 1'b1, 0);
        runCase("backpressure", 32'h0F0F_1234, 1'b0, 12'h3C0, 1'b0, 1'b1, 5);

        // Abort an ASR #0 partway through its shift cycles.
        @(negedge clk);
        val_rm        = 32'h8000_0000;
        shift_operand = 12'h040;
        imm           = 1'b0;
        is_memory_ins = 1'b0;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort val2", 64'(val2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runCase("post reset lsl", 32'h0000_00F1, 1'b0, 12'h200, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rRm  = $urandom;
            rSo  = 12'($urandom);
            rImm = ($urandom_range(0, 3) == 0);
            rMem = ($urandom_range(0, 3) == 0);
            runCase($sformatf("rand%0d", i), rRm, rImm, rSo, rMem, 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        lat = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
